// File: rtl/permutation_round_iter_if.sv
// Request/response bundle between the mode controller and the iterative ASCON permutation.
// State words are ordered [0:4] so that S[0] is the leftmost word of a concatenation.
interface permutation_round_iter_if;
  logic              start_i;
  logic              rounds_sel_i;
  logic [0:4][63:0]  state_i;
  logic              ready_o;
  logic              done_o;
  logic [0:4][63:0]  state_o;

  // Requester side (mode controller).
  modport master (
    output start_i,
    output rounds_sel_i,
    output state_i,
    input  ready_o,
    input  done_o,
    input  state_o
  );

  // Permutation side.
  modport slave (
    input  start_i,
    input  rounds_sel_i,
    input  state_i,
    output ready_o,
    output done_o,
    output state_o
  );
endinterface

// File: rtl/permutation_round_iter.sv
// Iterative ASCON permutation p^a / p^b: one round per clock (constant addition, bitsliced
// S-box layer, linear diffusion). The state register is the only storage on the datapath and is
// presented directly on state_o.
module permutation_round_iter #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  permutation_round_iter_if.slave   bus
);

  // Reject round counts the 4-bit counter scheme cannot represent.
  if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
    $fatal(1, "permutation_round_iter: ROUNDS_A=%0d out of range 1..12", ROUNDS_A);
  end
  if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
    $fatal(1, "permutation_round_iter: ROUNDS_B=%0d out of range 1..12", ROUNDS_B);
  end

  // The counter always ends at 11, so a shorter permutation just starts later in the sequence.
  localparam logic [3:0] CntStartA = 4'(12 - ROUNDS_A);
  localparam logic [3:0] CntStartB = 4'(12 - ROUNDS_B);
  localparam logic [3:0] CntLast   = 4'd11;

  typedef logic [0:4][63:0] state_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_e;

  fsm_e        fsm_q, fsm_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  state_t      round_out;

  // Rotate a 64-bit lane right by a constant amount.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
    return (x >> r) | (x << (64 - r));
  endfunction

  // Round constant for counter i lands in the low byte of S[2]: high nibble 15-i, low nibble i.
  function automatic state_t add_const(input state_t s, input logic [3:0] i);
    state_t o;
    o = s;
    o[2][7:0] = s[2][7:0] ^ {4'hF - i, i};
    return o;
  endfunction

  // Bitsliced 5-bit S-box applied to all 64 columns at once; S[0] is the column MSB.
  function automatic state_t sbox_layer(input state_t s);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    state_t      o;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2];
    x3 = s[3];
    x4 = s[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;

    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;

    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;

    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    o[0] = x0;
    o[1] = x1;
    o[2] = x2;
    o[3] = x3;
    o[4] = x4;
    return o;
  endfunction

  // Linear diffusion layer: each lane XORed with two rotations of itself.
  function automatic state_t diffusion(input state_t s);
    state_t o;
    o[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
    o[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
    o[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
    o[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
    o[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
    return o;
  endfunction

  // One full round on the registered state, purely combinational.
  always_comb begin
    round_out = diffusion(sbox_layer(add_const(state_q, cnt_q)));
  end

  // Next-state logic: load on accepted start, iterate in RUN, one-cycle DONE.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (fsm_q)
      StIdle: begin
        if (bus.start_i) begin
          fsm_d   = StRun;
          state_d = bus.state_i;
          cnt_d   = bus.rounds_sel_i ? CntStartB : CntStartA;
        end
      end
      StRun: begin
        state_d = round_out;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == CntLast) begin
          fsm_d = StDone;
        end
      end
      StDone: begin
        fsm_d = StIdle;
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  // State, counter and FSM registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs decode directly from the FSM; state_o is the register itself.
  always_comb begin
    bus.ready_o = (fsm_q == StIdle);
    bus.done_o  = (fsm_q == StDone);
    bus.state_o = state_q;
  end

endmodule

// File: tb/tb_permutation_round_iter.sv
// Self-checking bench for permutation_round_iter: random and fixed states compared against a
// table-driven reference model of the ASCON permutation.
module tb_permutation_round_iter;

  typedef logic [0:4][63:0] st_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  permutation_round_iter_if bus ();

  permutation_round_iter #(
    .ROUNDS_A (12),
    .ROUNDS_B (6)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

  localparam st_t VEC = {64'h8859263f4c5d6e8f, 64'h00c18e8584858607, 64'h7f7f7f7f7f7f7f8f,
                         64'h80c0848680808070, 64'h8888888a88888888};

  // Reference round i (0..11): constant, column-wise table S-box, rotate-XOR diffusion.
  function automatic st_t model_round(input st_t s, input int i);
    logic [63:0] w  [5];
    logic [63:0] nw [5];
    logic [4:0]  idx;
    logic [4:0]  o;
    st_t         r;
    for (int j = 0; j < 5; j++) w[j] = s[j];
    w[2] = w[2] ^ 64'((15 - i) * 16 + i);
    for (int j = 0; j < 5; j++) nw[j] = '0;
    for (int k = 0; k < 64; k++) begin
      idx = {w[0][k], w[1][k], w[2][k], w[3][k], w[4][k]};
      o   = SBOX[idx];
      for (int j = 0; j < 5; j++) nw[j][k] = o[4-j];
    end
    for (int j = 0; j < 5; j++) begin
      r[j] = nw[j] ^ ((nw[j] >> ROT1[j]) | (nw[j] << (64 - ROT1[j])))
                   ^ ((nw[j] >> ROT2[j]) | (nw[j] << (64 - ROT2[j])));
    end
    return r;
  endfunction

  // Reference p^n: the last n constants of the twelve-round sequence.
  function automatic st_t model_perm(input st_t s, input int n);
    st_t r;
    r = s;
    for (int i = 12 - n; i < 12; i++) r = model_round(r, i);
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    for (int j = 0; j < 5; j++) r[j] = {$urandom, $urandom};
    return r;
  endfunction

  // Advance one clock; inputs and samples both sit 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle start; returns in cycle 1 after the accepting edge.
  task automatic do_start(input logic sel, input st_t s);
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = sel;
    bus.state_i      = s;
    tick();
    bus.start_i      = 1'b0;
    bus.rounds_sel_i = $urandom_range(0, 1);
    bus.state_i      = rand_state();
  endtask

  // Ticks until done_o is seen, bounded at 40.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done_o !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", bus.ready_o);
    end
    n_cmp++;
    if (bus.done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", bus.done_o);
    end
    n_cmp++;
    if (bus.state_o !== st_t'(0)) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", bus.state_o);
    end
  endtask

  task automatic test_p12_timing();
    st_t s;
    st_t exp;
    int  bad_ready;
    int  bad_done;
    s = rand_state();
    exp = model_perm(s, 12);
    do_start(1'b0, s);
    bad_ready = 0;
    bad_done  = 0;
    for (int k = 1; k <= 15; k++) begin
      if (bus.ready_o !== (k <= 13 ? 1'b0 : 1'b1)) bad_ready++;
      if (bus.done_o !== (k == 13 ? 1'b1 : 1'b0)) bad_done++;
      if (k == 13) begin
        n_cmp++;
        if (bus.state_o !== exp) begin
          n_err++;
          $display("FAIL p12_result: got %h want %h", bus.state_o, exp);
        end
      end
      if (k == 15) begin
        n_cmp++;
        if (bus.state_o !== exp) begin
          n_err++;
          $display("FAIL p12_idle_hold: got %h want %h", bus.state_o, exp);
        end
      end
      tick();
    end
    n_cmp++;
    if (bad_ready != 0) begin
      n_err++;
      $display("FAIL p12_ready_window: got %0d wrong cycles want 0", bad_ready);
    end
    n_cmp++;
    if (bad_done != 0) begin
      n_err++;
      $display("FAIL p12_done_window: got %0d wrong cycles want 0", bad_done);
    end
  endtask

  // Fixed vector, checked after every round so the constant sequence is visible.
  task automatic test_round_data(input logic sel, input int n);
    st_t exp;
    int  cyc;
    do_start(sel, VEC);
    n_cmp++;
    if (bus.state_o !== VEC) begin
      n_err++;
      $display("FAIL load_n%0d: got %h want %h", n, bus.state_o, VEC);
    end
    exp = VEC;
    for (int r = 0; r < n; r++) begin
      tick();
      exp = model_round(exp, 12 - n + r);
      n_cmp++;
      if (bus.state_o !== exp) begin
        n_err++;
        $display("FAIL round_n%0d_r%0d: got %h want %h", n, r + 1, bus.state_o, exp);
      end
    end
    n_cmp++;
    if (bus.done_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_after_n%0d: got %b want 1", n, bus.done_o);
    end
    n_cmp++;
    if (bus.state_o !== model_perm(VEC, n)) begin
      n_err++;
      $display("FAIL perm_n%0d: got %h want %h", n, bus.state_o, model_perm(VEC, n));
    end
    wait_done(cyc);
    tick();
  endtask

  task automatic test_random();
    st_t  s;
    logic sel;
    int   n;
    int   cyc;
    for (int it = 0; it < 8; it++) begin
      s   = rand_state();
      sel = $urandom_range(0, 1);
      n   = sel ? 6 : 12;
      do_start(sel, s);
      wait_done(cyc);
      n_cmp++;
      if (cyc != n) begin
        n_err++;
        $display("FAIL rand%0d_latency: got %0d want %0d", it, cyc, n);
      end
      n_cmp++;
      if (bus.state_o !== model_perm(s, n)) begin
        n_err++;
        $display("FAIL rand%0d_result: got %h want %h", it, bus.state_o, model_perm(s, n));
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    st_t s;
    st_t s2;
    st_t exp;
    int  cyc;
    s   = rand_state();
    exp = model_perm(s, 12);
    do_start(1'b0, s);
    tick();
    tick();
    // RUN cycle 3: a competing request with different data and selection.
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = 1'b1;
    bus.state_i      = rand_state();
    tick();
    bus.start_i      = 1'b0;
    wait_done(cyc);
    n_cmp++;
    if (3 + cyc != 12) begin
      n_err++;
      $display("FAIL ign_run_latency: got %0d want 12", 3 + cyc);
    end
    n_cmp++;
    if (bus.state_o !== exp) begin
      n_err++;
      $display("FAIL ign_run_result: got %h want %h", bus.state_o, exp);
    end
    // Pulse during DONE only: must not be taken.
    bus.start_i = 1'b1;
    bus.state_i = rand_state();
    tick();
    bus.start_i = 1'b0;
    tick();
    n_cmp++;
    if (bus.ready_o !== 1'b1 || bus.state_o !== exp) begin
      n_err++;
      $display("FAIL ign_done_pulse: got ready=%b state=%h want ready=1 state=%h",
               bus.ready_o, bus.state_o, exp);
    end
    // Start held from DONE into IDLE: accepted on the first ready edge.
    do_start(1'b1, rand_state());
    wait_done(cyc);
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = 1'b1;
    s2               = rand_state();
    bus.state_i      = s2;
    tick();
    n_cmp++;
    if (bus.ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL held_idle_ready: got %b want 1", bus.ready_o);
    end
    tick();
    bus.start_i = 1'b0;
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.state_o !== s2) begin
      n_err++;
      $display("FAIL held_accept: got ready=%b state=%h want ready=0 state=%h",
               bus.ready_o, bus.state_o, s2);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc != 6 || bus.state_o !== model_perm(s2, 6)) begin
      n_err++;
      $display("FAIL held_result: got cyc=%0d state=%h want cyc=6 state=%h",
               cyc, bus.state_o, model_perm(s2, 6));
    end
    tick();
  endtask

  task automatic test_midrun_reset();
    st_t s;
    int  dones;
    int  cyc;
    do_start(1'b0, rand_state());
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.state_o !== st_t'(0)) begin
      n_err++;
      $display("FAIL midrst_state: got ready=%b done=%b state=%h want ready=1 done=0 state=0",
               bus.ready_o, bus.done_o, bus.state_o);
    end
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.done_o === 1'b1) dones++;
      tick();
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL midrst_no_done: got %0d done cycles want 0", dones);
    end
    s = rand_state();
    do_start(1'b0, s);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 12 || bus.state_o !== model_perm(s, 12)) begin
      n_err++;
      $display("FAIL midrst_fresh: got cyc=%0d state=%h want cyc=12 state=%h",
               cyc, bus.state_o, model_perm(s, 12));
    end
    tick();
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.rounds_sel_i = 1'b0;
    bus.state_i      = '0;
    test_reset();
    test_p12_timing();
    test_round_data(1'b0, 12);
    test_round_data(1'b1, 6);
    test_random();
    test_start_ignored();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
